// File: rtl/tile_sequencer.sv
// Tiling sequencer for the DIM x DIM systolic array: walks (nt, kt) tiles,
// drives buffer/array enables and per-lane operand addresses with valids.
// Ports: clk, rst (sync, active-high); start/abort/cfg_m/cfg_k/cfg_n control;
//        busy/done/err status; s_addr/s_valid, t_addr/t_valid lane buses;
//        s_load_en, t_load_en, s_out_en, write_weight_en, t_out_en,
//        o_load_en, o_out_en, acc_first enables; o_row/o_col_base unload tag.
module tile_sequencer #(
    parameter int DIM      = 16,
    parameter int DIM_W    = 12,
    parameter int ADDR_W   = 24,
    parameter int PIPE_LAT = 2 * DIM
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  abort,
    input  logic [DIM_W-1:0]      cfg_m,
    input  logic [DIM_W-1:0]      cfg_k,
    input  logic [DIM_W-1:0]      cfg_n,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [DIM*ADDR_W-1:0] s_addr,
    output logic [DIM-1:0]        s_valid,
    output logic [DIM*ADDR_W-1:0] t_addr,
    output logic [DIM-1:0]        t_valid,
    output logic                  s_load_en,
    output logic                  t_load_en,
    output logic                  s_out_en,
    output logic                  write_weight_en,
    output logic                  t_out_en,
    output logic                  o_load_en,
    output logic                  o_out_en,
    output logic                  acc_first,
    output logic [DIM_W-1:0]      o_row,
    output logic [DIM_W-1:0]      o_col_base
);

    localparam int LG = $clog2(DIM);
    localparam int KW = DIM_W + 2;
    localparam int CW = DIM_W + 2;

    typedef enum logic [2:0] {
        IDLE, LOAD_S, LOAD_T, COMPUTE, UNLOAD, DONE
    } state_e;

    state_e            state_q, state_d;
    logic [CW-1:0]     c_q, c_d;
    logic [DIM_W-1:0]  kt_q, kt_d, nt_q, nt_d;
    logic [DIM_W-1:0]  m_q, m_d, k_q, k_d, n_q, n_d;
    logic              bad_q, bad_d;

    logic [CW-1:0]     m_c, lt_len, cp_len;
    logic [KW-1:0]     kt_end, nt_end;

    // Registered outputs
    logic                  busy_q, busy_d, done_q, done_d, err_q, err_d;
    logic [DIM*ADDR_W-1:0] s_addr_q, s_addr_d, t_addr_q, t_addr_d;
    logic [DIM-1:0]        s_valid_q, s_valid_d, t_valid_q, t_valid_d;
    logic                  s_load_en_q, s_load_en_d, t_load_en_q, t_load_en_d;
    logic                  s_out_en_q, s_out_en_d, wwe_q, wwe_d;
    logic                  t_out_en_q, t_out_en_d, o_load_en_q, o_load_en_d;
    logic                  o_out_en_q, o_out_en_d, acc_first_q, acc_first_d;
    logic [DIM_W-1:0]      o_row_q, o_row_d, o_col_base_q, o_col_base_d;

    logic [KW-1:0]     kb, nb, lk, ln;

    // Sequencing: phase counter plus (kt, nt) tile indices
    always_comb begin
        state_d = state_q;
        c_d     = c_q + CW'(1);
        kt_d    = kt_q;
        nt_d    = nt_q;
        m_d     = m_q;
        k_d     = k_q;
        n_d     = n_q;
        bad_d   = bad_q;
        m_c     = CW'(m_q);
        lt_len  = (m_c > CW'(DIM)) ? m_c : CW'(DIM);
        cp_len  = CW'(PIPE_LAT) + m_c;
        // Tile is the last along an axis once its end reaches the dimension
        kt_end  = (KW'(kt_q) + KW'(1)) << LG;
        nt_end  = (KW'(nt_q) + KW'(1)) << LG;
        unique case (state_q)
            IDLE: begin
                c_d = '0;
                if (start) begin
                    m_d  = cfg_m;
                    k_d  = cfg_k;
                    n_d  = cfg_n;
                    kt_d = '0;
                    nt_d = '0;
                    if (cfg_m == '0 || cfg_k == '0 || cfg_n == '0) begin
                        bad_d   = 1'b1;
                        state_d = DONE;
                    end else begin
                        bad_d   = 1'b0;
                        state_d = LOAD_S;
                    end
                end
            end
            LOAD_S: begin
                if (c_q == CW'(DIM - 1)) begin
                    c_d     = '0;
                    state_d = LOAD_T;
                end
            end
            LOAD_T: begin
                if (c_q == lt_len - CW'(1)) begin
                    c_d     = '0;
                    state_d = COMPUTE;
                end
            end
            COMPUTE: begin
                if (c_q == cp_len - CW'(1)) begin
                    c_d = '0;
                    if (kt_end >= KW'(k_q)) begin
                        state_d = UNLOAD;
                    end else begin
                        kt_d    = kt_q + DIM_W'(1);
                        state_d = LOAD_S;
                    end
                end
            end
            UNLOAD: begin
                if (c_q == m_c - CW'(1)) begin
                    c_d = '0;
                    if (nt_end >= KW'(n_q)) begin
                        state_d = DONE;
                    end else begin
                        kt_d    = '0;
                        nt_d    = nt_q + DIM_W'(1);
                        state_d = LOAD_S;
                    end
                end
            end
            DONE: begin
                c_d     = '0;
                state_d = IDLE;
            end
            default: begin
                c_d     = '0;
                state_d = IDLE;
            end
        endcase
        if (abort) begin
            c_d     = '0;
            state_d = IDLE;
        end
    end

    // Outputs are decoded from the next state so they register alongside it
    always_comb begin
        busy_d       = (state_d != IDLE) && (state_d != DONE);
        done_d       = (state_d == DONE);
        err_d        = (state_d == DONE) && bad_d;
        s_addr_d     = '0;
        s_valid_d    = '0;
        t_addr_d     = '0;
        t_valid_d    = '0;
        s_load_en_d  = 1'b0;
        t_load_en_d  = 1'b0;
        s_out_en_d   = 1'b0;
        wwe_d        = 1'b0;
        t_out_en_d   = 1'b0;
        o_load_en_d  = 1'b0;
        o_out_en_d   = 1'b0;
        acc_first_d  = 1'b0;
        o_row_d      = '0;
        o_col_base_d = '0;
        kb           = KW'(kt_d) << LG;
        nb           = KW'(nt_d) << LG;
        lk           = '0;
        ln           = '0;
        unique case (state_d)
            LOAD_S: begin
                s_load_en_d = 1'b1;
                for (int j = 0; j < DIM; j++) begin
                    lk = kb + KW'(c_d);
                    ln = nb + KW'(j);
                    if (lk < KW'(k_d) && ln < KW'(n_d)) begin
                        s_valid_d[j] = 1'b1;
                        s_addr_d[j*ADDR_W +: ADDR_W] =
                            ADDR_W'(lk) * ADDR_W'(n_d) + ADDR_W'(ln);
                    end
                end
            end
            LOAD_T: begin
                if (c_d < CW'(m_d)) begin
                    t_load_en_d = 1'b1;
                    for (int j = 0; j < DIM; j++) begin
                        lk = kb + KW'(j);
                        if (lk < KW'(k_d)) begin
                            t_valid_d[j] = 1'b1;
                            t_addr_d[j*ADDR_W +: ADDR_W] =
                                ADDR_W'(c_d) * ADDR_W'(k_d) + ADDR_W'(lk);
                        end
                    end
                end
                // Array weight write overlaps the first DIM cycles of T load
                s_out_en_d = (c_d < CW'(DIM));
                wwe_d      = (c_d < CW'(DIM));
            end
            COMPUTE: begin
                t_out_en_d  = (c_d < CW'(m_d));
                o_load_en_d = (c_d >= CW'(PIPE_LAT)) &&
                              (c_d < CW'(PIPE_LAT) + CW'(m_d));
                acc_first_d = (kt_d == '0);
            end
            UNLOAD: begin
                o_out_en_d   = 1'b1;
                o_row_d      = DIM_W'(c_d);
                o_col_base_d = DIM_W'(nb);
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            c_q          <= '0;
            kt_q         <= '0;
            nt_q         <= '0;
            m_q          <= '0;
            k_q          <= '0;
            n_q          <= '0;
            bad_q        <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            s_addr_q     <= '0;
            s_valid_q    <= '0;
            t_addr_q     <= '0;
            t_valid_q    <= '0;
            s_load_en_q  <= 1'b0;
            t_load_en_q  <= 1'b0;
            s_out_en_q   <= 1'b0;
            wwe_q        <= 1'b0;
            t_out_en_q   <= 1'b0;
            o_load_en_q  <= 1'b0;
            o_out_en_q   <= 1'b0;
            acc_first_q  <= 1'b0;
            o_row_q      <= '0;
            o_col_base_q <= '0;
        end else begin
            state_q      <= state_d;
            c_q          <= c_d;
            kt_q         <= kt_d;
            nt_q         <= nt_d;
            m_q          <= m_d;
            k_q          <= k_d;
            n_q          <= n_d;
            bad_q        <= bad_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            err_q        <= err_d;
            s_addr_q     <= s_addr_d;
            s_valid_q    <= s_valid_d;
            t_addr_q     <= t_addr_d;
            t_valid_q    <= t_valid_d;
            s_load_en_q  <= s_load_en_d;
            t_load_en_q  <= t_load_en_d;
            s_out_en_q   <= s_out_en_d;
            wwe_q        <= wwe_d;
            t_out_en_q   <= t_out_en_d;
            o_load_en_q  <= o_load_en_d;
            o_out_en_q   <= o_out_en_d;
            acc_first_q  <= acc_first_d;
            o_row_q      <= o_row_d;
            o_col_base_q <= o_col_base_d;
        end
    end

    assign busy            = busy_q;
    assign done            = done_q;
    assign err             = err_q;
    assign s_addr          = s_addr_q;
    assign s_valid         = s_valid_q;
    assign t_addr          = t_addr_q;
    assign t_valid         = t_valid_q;
    assign s_load_en       = s_load_en_q;
    assign t_load_en       = t_load_en_q;
    assign s_out_en        = s_out_en_q;
    assign write_weight_en = wwe_q;
    assign t_out_en        = t_out_en_q;
    assign o_load_en       = o_load_en_q;
    assign o_out_en        = o_out_en_q;
    assign acc_first       = acc_first_q;
    assign o_row           = o_row_q;
    assign o_col_base      = o_col_base_q;

endmodule

// File: tb/tb_tile_sequencer.sv
// Bench for tile_sequencer: a cycle trace built from the tiling loops is
// compared beat-by-beat against the registered outputs.
module tb_tile_sequencer;

    localparam int DIM = 4;
    localparam int DW  = 8;
    localparam int AW  = 16;
    localparam int PL  = 8;

    typedef struct packed {
        logic          busy;
        logic          done;
        logic          err;
        logic [DIM*AW-1:0] s_addr;
        logic [DIM-1:0]    s_valid;
        logic [DIM*AW-1:0] t_addr;
        logic [DIM-1:0]    t_valid;
        logic          s_load_en;
        logic          t_load_en;
        logic          s_out_en;
        logic          write_weight_en;
        logic          t_out_en;
        logic          o_load_en;
        logic          o_out_en;
        logic          acc_first;
        logic [DW-1:0] o_row;
        logic [DW-1:0] o_col_base;
    } beat_t;

    logic              clk = 1'b0;
    logic              rst, start, abort;
    logic [DW-1:0]     cfg_m, cfg_k, cfg_n;
    logic              busy, done, err;
    logic [DIM*AW-1:0] s_addr, t_addr;
    logic [DIM-1:0]    s_valid, t_valid;
    logic              s_load_en, t_load_en, s_out_en, write_weight_en;
    logic              t_out_en, o_load_en, o_out_en, acc_first;
    logic [DW-1:0]     o_row, o_col_base;

    int    n_chk  = 0;
    int    n_pass = 0;
    beat_t exp_q[$];
    int    busy_cnt, done_cnt, lane1_c2;

    tile_sequencer #(
        .DIM(DIM), .DIM_W(DW), .ADDR_W(AW), .PIPE_LAT(PL)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .cfg_m(cfg_m), .cfg_k(cfg_k), .cfg_n(cfg_n),
        .busy(busy), .done(done), .err(err),
        .s_addr(s_addr), .s_valid(s_valid),
        .t_addr(t_addr), .t_valid(t_valid),
        .s_load_en(s_load_en), .t_load_en(t_load_en),
        .s_out_en(s_out_en), .write_weight_en(write_weight_en),
        .t_out_en(t_out_en), .o_load_en(o_load_en),
        .o_out_en(o_out_en), .acc_first(acc_first),
        .o_row(o_row), .o_col_base(o_col_base)
    );

    always #5 clk = ~clk;

    function automatic beat_t sample();
        beat_t b;
        b = '{busy, done, err, s_addr, s_valid, t_addr, t_valid,
              s_load_en, t_load_en, s_out_en, write_weight_en,
              t_out_en, o_load_en, o_out_en, acc_first, o_row, o_col_base};
        return b;
    endfunction

    // Expected per-cycle trace straight from the tile loop description
    function automatic void build(int m, int k, int n);
        beat_t b;
        int kt_n, nt_n, kk, nn;
        exp_q.delete();
        kt_n = (k + DIM - 1) / DIM;
        nt_n = (n + DIM - 1) / DIM;
        if (m == 0 || k == 0 || n == 0) begin
            kt_n = 0;
            nt_n = 0;
        end
        for (int nt = 0; nt < nt_n; nt++) begin
            for (int kt = 0; kt < kt_n; kt++) begin
                for (int c = 0; c < DIM; c++) begin
                    b = '0; b.busy = 1'b1; b.s_load_en = 1'b1;
                    for (int j = 0; j < DIM; j++) begin
                        kk = kt * DIM + c;
                        nn = nt * DIM + j;
                        if (kk < k && nn < n) begin
                            b.s_valid[j] = 1'b1;
                            b.s_addr[j*AW +: AW] = AW'(kk * n + nn);
                        end
                    end
                    exp_q.push_back(b);
                end
                for (int c = 0; c < ((m > DIM) ? m : DIM); c++) begin
                    b = '0; b.busy = 1'b1;
                    if (c < m) begin
                        b.t_load_en = 1'b1;
                        for (int j = 0; j < DIM; j++) begin
                            kk = kt * DIM + j;
                            if (kk < k) begin
                                b.t_valid[j] = 1'b1;
                                b.t_addr[j*AW +: AW] = AW'(c * k + kk);
                            end
                        end
                    end
                    b.s_out_en        = (c < DIM);
                    b.write_weight_en = (c < DIM);
                    exp_q.push_back(b);
                end
                for (int c = 0; c < PL + m; c++) begin
                    b = '0; b.busy = 1'b1;
                    b.t_out_en  = (c < m);
                    b.o_load_en = (c >= PL);
                    b.acc_first = (kt == 0);
                    exp_q.push_back(b);
                end
            end
            for (int c = 0; c < m; c++) begin
                b = '0; b.busy = 1'b1; b.o_out_en = 1'b1;
                b.o_row = DW'(c);
                b.o_col_base = DW'(nt * DIM);
                exp_q.push_back(b);
            end
        end
        b = '0; b.done = 1'b1; b.err = (kt_n == 0);
        exp_q.push_back(b);
        b = '0;
        exp_q.push_back(b);
    endfunction

    function automatic int busy_formula(int m, int k, int n);
        int kt_n, nt_n;
        if (m == 0 || k == 0 || n == 0) return 0;
        kt_n = (k + DIM - 1) / DIM;
        nt_n = (n + DIM - 1) / DIM;
        return kt_n * nt_n * (DIM + ((m > DIM) ? m : DIM) + PL + m) + nt_n * m;
    endfunction

    task automatic chk_beat(string tag, int idx, beat_t o, beat_t e);
        n_chk++;
        assert (o === e) n_pass++;
        else $error("FAIL %s beat %0d: got %h want %h", tag, idx, o, e);
    endtask

    task automatic chk_int(string tag, int o, int e);
        n_chk++;
        assert (o === e) n_pass++;
        else $error("FAIL %s: got %0d want %0d", tag, o, e);
    endtask

    // kind: 0 none, 1 abort, 2 stray start, 3 reset; applied after beat 'at'
    task automatic run(string tag, int m, int k, int n, int kind, int at);
        beat_t o, e;
        int idx;
        build(m, k, n);
        if (kind == 1 || kind == 3) begin
            exp_q = exp_q[0:at];
            e = '0;
            exp_q.push_back(e);
        end
        busy_cnt = 0; done_cnt = 0; lane1_c2 = -1;
        @(negedge clk);
        cfg_m = DW'(m); cfg_k = DW'(k); cfg_n = DW'(n);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        idx = 0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = sample();
            chk_beat(tag, idx, o, e);
            if (busy) busy_cnt++;
            if (done) done_cnt++;
            if (idx == 2) lane1_c2 = int'(s_addr[AW +: AW]);
            @(negedge clk);
            if (idx == at) begin
                if (kind == 1) abort = 1'b1;
                if (kind == 2) begin
                    cfg_m = DW'($urandom_range(1, 9));
                    cfg_k = DW'($urandom_range(1, 9));
                    cfg_n = DW'($urandom_range(1, 9));
                    start = 1'b1;
                end
                if (kind == 3) rst = 1'b1;
            end
            @(posedge clk); #1;
            abort = 1'b0; start = 1'b0; rst = 1'b0;
            idx++;
        end
    endtask

    initial begin
        int m, k, n;
        beat_t zero;
        zero = '0;
        rst = 1'b1; start = 1'b0; abort = 1'b0;
        cfg_m = '0; cfg_k = '0; cfg_n = '0;
        repeat (3) @(posedge clk);
        #1;
        chk_beat("reset", 0, sample(), zero);
        rst = 1'b0;

        run("base", 3, 4, 4, 0, -1);
        chk_int("base_busy", busy_cnt, 22);
        chk_int("base_done", done_cnt, 1);
        chk_int("base_saddr", lane1_c2, 9);

        run("ktile", 3, 5, 4, 0, -1);
        chk_int("ktile_busy", busy_cnt, 41);
        chk_int("ktile_done", done_cnt, 1);

        run("ntile", 2, 4, 6, 0, -1);
        chk_int("ntile_busy", busy_cnt, 40);

        run("zero_k", 3, 0, 4, 0, -1);
        chk_int("zero_busy", busy_cnt, 0);
        chk_int("zero_done", done_cnt, 1);

        run("abort", 3, 4, 4, 1, 13);
        chk_int("abort_done", done_cnt, 0);
        run("post_abort", 3, 4, 4, 0, -1);
        chk_int("post_abort_busy", busy_cnt, 22);

        run("stray_start", 3, 4, 4, 2, 5);
        chk_int("stray_busy", busy_cnt, 22);
        chk_int("stray_done", done_cnt, 1);

        run("rst_mid", 3, 4, 4, 3, 1);
        chk_int("rst_done", done_cnt, 0);

        for (int r = 0; r < 8; r++) begin
            m = int'($urandom_range(1, 6));
            k = int'($urandom_range(1, 10));
            n = int'($urandom_range(1, 10));
            if (r == 7) m = 0;
            run("rand", m, k, n, 0, -1);
            chk_int("rand_busy", busy_cnt, busy_formula(m, k, n));
            chk_int("rand_done", done_cnt, 1);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/tile_sequencer.md
# tile_sequencer

Runtime-configurable tiling sequencer for the DIM×DIM systolic accelerator: computes C[M×N] = T[M×K] · S[K×N] for arbitrary M, K, N. It drives the buffer and array enables and produces per-lane read addresses with valid bits for both operands, including edge tiles where K or N is not a multiple of DIM. It sits between operand memories and `accelerator` and replaces hand-sequenced enable timing.

## Interface
- DIM, 16, array dimension; power of two ≥ 2
- DIM_W, 12, width of cfg_m/cfg_k/cfg_n
- ADDR_W, 24, element address width per lane
- PIPE_LAT, 2*DIM, cycles from first stream_out_en to first result row at the array output
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- start  in  1  begin job; sampled only in IDLE
- abort  in  1  synchronous abort; returns to IDLE without done
- cfg_m, cfg_k, cfg_n  in  DIM_W each  matrix dimensions; latched on accepted start
- busy  out  1  job in progress
- done  out  1  one-cycle completion pulse
- err  out  1  valid with done; 1 = a cfg dimension was zero
- s_addr  out  DIM*ADDR_W  stationary-operand lane addresses; lane j at [j*ADDR_W +: ADDR_W]
- s_valid  out  DIM  per-lane valid for s_addr
- t_addr  out  DIM*ADDR_W  streamed-operand lane addresses
- t_valid  out  DIM  per-lane valid for t_addr
- s_load_en, t_load_en, s_out_en, write_weight_en, t_out_en, o_load_en, o_out_en  out  1 each  buffer/array enables
- acc_first  out  1  qualifies o_load_en: 1 = overwrite, 0 = accumulate
- o_row  out  DIM_W  row index of current o_out_en beat
- o_col_base  out  DIM_W  column base (nt*DIM) of current o_out_en beat

## Operation
- States: IDLE, LOAD_S, LOAD_T, COMPUTE, UNLOAD, DONE.
- Tiles: KT = ceil(K/DIM), NT = ceil(N/DIM). Loop order nt outer, kt inner. Per (kt,nt): LOAD_S → LOAD_T → COMPUTE; UNLOAD follows COMPUTE only when kt = KT-1.
- Phase counter c restarts at 0 on entry to each phase.
- LOAD_S, DIM cycles: s_load_en=1. Lane j: k = kt*DIM+c, n = nt*DIM+j, s_addr = k*N+n, s_valid = (k<K && n<N).
- LOAD_T, max(M,DIM) cycles. For c<M: t_load_en=1. Lane j: k = kt*DIM+j, t_addr = c*K+k, t_valid = (k<K). For c<DIM: s_out_en=write_weight_en=1 (overlapped array write).
- COMPUTE, PIPE_LAT+M cycles: t_out_en=1 for c<M; o_load_en=1 for PIPE_LAT ≤ c < PIPE_LAT+M; acc_first=(kt==0).
- UNLOAD, M cycles: o_out_en=1, o_row=c, o_col_base=nt*DIM.
- After the last UNLOAD of nt=NT-1 → DONE (one cycle) → IDLE.
- Invalid lanes drive address 0. All outputs not named active in the current phase are 0.
- start with any cfg = 0: no tiles; DONE next cycle with err=1.
- start while busy: ignored. abort: IDLE next cycle, all outputs 0, no done. abort has priority over start.
- rst: IDLE; busy, done, err, all enables, valids, addresses, o_row, o_col_base = 0. Reset mid-job discards the job.

## Timing
- All outputs registered. The edge that samples start in IDLE makes LOAD_S c=0 outputs and busy=1 visible in the following cycle.
- Phase transitions have no bubbles: last cycle of one phase is followed directly by c=0 of the next.
- busy cycles = Σ over tiles [DIM + max(M,DIM) + PIPE_LAT + M] + NT*M. The DONE cycle has done=1, busy=0.
- Address arithmetic is full precision, truncated to ADDR_W; cfg products must fit ADDR_W (caller's responsibility).

## Test plan
- DIM=4, PIPE_LAT=8, M=3,K=4,N=4 → busy for exactly 22 cycles (4+4+11+3); done pulses once; LOAD_S c=2 lane 1 s_addr=9; 3 o_out_en beats o_row 0,1,2.
- M=3,K=5,N=4 → KT=2; kt=1 LOAD_S: only row c=0 has s_valid=4'b1111, rows 1–3 have s_valid=0; t_valid=4'b0001; acc_first=0 during kt=1 o_load_en; single UNLOAD, after kt=1.
- M=2,K=4,N=6 → NT=2; nt=1 s_valid=4'b0011; o_col_base=4 in second UNLOAD; LOAD_T still 4 cycles, t_load_en only c=0,1.
- cfg_k=0 → done=1, err=1 in the cycle after start; no enable ever asserted.
- abort in COMPUTE c=5 → next cycle all outputs 0, busy=0, no done; a new start is then accepted normally.
- start pulsed during LOAD_T → ignored, cycle count unchanged; rst mid-LOAD_S → all outputs 0 in the following cycle.
